// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection for the fetch PC register with stall-held branch redirect
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        is_br,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        flush,
  output logic        bd_f,
  output logic        fetch_adel
);
  typedef enum logic {RUN, PEND} state_t;
  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        bd_q, bd_d;
  logic [31:0] seq_pc;
  assign seq_pc     = pc_cur + 32'd4;
  assign bd_f       = bd_q;
  assign fetch_adel = (|pc_cur[1:0]) || (pc_cur < IMEM_LO) || (pc_cur > IMEM_HI);
  // state, pending target and delay-slot flag; reset is folded into the next-state logic
  always_ff @(posedge clk) begin
    state_q <= state_d;
    pend_q  <= pend_d;
    bd_q    <= bd_d;
  end
  // priority: reset > exception > eret > stall > pending redirect > branch > sequential
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    bd_d    = bd_q;
    pc_next = seq_pc;
    pc_en   = 1'b0;
    flush   = 1'b0;
    if (reset) begin
      pc_next = RESET_PC;
      state_d = RUN;
      pend_d  = '0;
      bd_d    = 1'b0;
    end else if (exc_req || eret_req) begin
      pc_next = exc_req ? EXC_VECTOR : epc;
      pc_en   = 1'b1;
      flush   = 1'b1;
      state_d = RUN;
      pend_d  = '0;
      bd_d    = 1'b0;
    end else if (stall) begin
      if (state_q == RUN && br_taken) begin
        pend_d  = br_target;
        state_d = PEND;
      end
    end else begin
      pc_en   = 1'b1;
      bd_d    = is_br;
      pc_next = (state_q == PEND) ? pend_q : (br_taken ? br_target : seq_pc);
      state_d = RUN;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of next-PC selection, stall redirect, exceptions and fetch address checks
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, is_br, br_taken, exc_req, eret_req;
  logic [31:0] pc_cur, br_target, epc;
  logic [31:0] pc_next;
  logic        pc_en, flush, bd_f, fetch_adel;
  int          passed = 0, total = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall), .is_br(is_br),
    .br_taken(br_taken), .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc_next(pc_next), .pc_en(pc_en), .flush(flush), .bd_f(bd_f),
    .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; stall = 0; is_br = 0; br_taken = 0; exc_req = 0; eret_req = 0;
    pc_cur = 32'h3000; br_target = 0; epc = 0;
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_next", pc_next, 32'h3000);
    chk("rst_flush", flush, 0);
    tick(); tick();
    reset = 0; #1;
    chk("rst_bd_f", bd_f, 0);
    chk("seq_pc_next", pc_next, 32'h3004);
    chk("seq_pc_en", pc_en, 1);
    chk("seq_adel", fetch_adel, 0);
    tick();
    chk("seq_bd_f", bd_f, 0);

    stall = 1; br_taken = 1; is_br = 1; br_target = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_pc_en", pc_en, 0);
      chk("stall_flush", flush, 0);
      chk("stall_bd_hold", bd_f, 0);
      tick();
    end
    stall = 0; br_target = 32'h3200; #1;
    chk("release_pc_next", pc_next, 32'h3100);
    chk("release_pc_en", pc_en, 1);
    tick();
    chk("release_bd_f", bd_f, 1);
    br_taken = 0; is_br = 0; pc_cur = 32'h3100; #1;
    chk("after_release_run", pc_next, 32'h3104);
    tick();
    chk("slot_bd_clear", bd_f, 0);

    br_taken = 1; is_br = 1; br_target = 32'h3300; #1;
    chk("br_direct", pc_next, 32'h3300);
    tick();
    chk("br_direct_bd", bd_f, 1);

    stall = 1; br_target = 32'h3100; tick();
    exc_req = 1; #1;
    chk("exc_pc_next", pc_next, 32'h4180);
    chk("exc_pc_en", pc_en, 1);
    chk("exc_flush", flush, 1);
    tick();
    chk("exc_bd_f", bd_f, 0);
    exc_req = 0; stall = 0; br_taken = 0; is_br = 0; pc_cur = 32'h4180; #1;
    chk("exc_pend_dropped", pc_next, 32'h4184);
    chk("exc_after_flush", flush, 0);

    exc_req = 1; eret_req = 1; epc = 32'h3044; #1;
    chk("exc_over_eret", pc_next, 32'h4180);
    exc_req = 0; #1;
    chk("eret_pc_next", pc_next, 32'h3044);
    chk("eret_flush", flush, 1);
    chk("eret_pc_en", pc_en, 1);
    tick();
    eret_req = 0;

    pc_cur = 32'h3002; #1 chk("adel_misalign", fetch_adel, 1);
    pc_cur = 32'h2FFC; #1 chk("adel_below", fetch_adel, 1);
    pc_cur = 32'h7000; #1 chk("adel_above", fetch_adel, 1);
    pc_cur = 32'h6FFC; #1 chk("adel_hi_ok", fetch_adel, 0);
    pc_cur = 32'h3000; #1 chk("adel_lo_ok", fetch_adel, 0);
    pc_cur = 32'hFFFF_FFFC; #1;
    chk("wrap_pc_next", pc_next, 32'h0);
    chk("wrap_adel", fetch_adel, 1);

    pc_cur = 32'h3000; is_br = 1; tick();
    chk("pre_rst_bd", bd_f, 1);
    stall = 1; br_taken = 1; br_target = 32'h3100; tick();
    reset = 1; #1;
    chk("rst_pend_pc_en", pc_en, 0);
    chk("rst_pend_pc_next", pc_next, 32'h3000);
    tick();
    reset = 0; stall = 0; br_taken = 0; is_br = 0; #1;
    chk("rst_pend_bd", bd_f, 0);
    chk("rst_pend_seq", pc_next, 32'h3004);
    chk("rst_pend_en", pc_en, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the five-stage MIPS pipeline. It drives the write enable and data input of the fetch PC register. Each cycle it chooses among sequential fetch, branch/jump redirect, exception vector entry and ERET return. It keeps a branch redirect that arrives during a stall, tracks branch-delay-slot status for CP0, and flags illegal fetch addresses.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, reset/boot address
- EXC_VECTOR, 32'h0000_4180, exception handler entry
- IMEM_LO, 32'h0000_3000, lowest legal fetch address
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_cur  in  32  current PC register output (F stage)
- stall  in  1  hazard-unit freeze of F/D
- is_br  in  1  D stage holds a branch/jump instruction, taken or not
- br_taken  in  1  D-stage branch/jump resolved taken
- br_target  in  32  D-stage redirect target
- exc_req  in  1  CP0 exception/interrupt entry request
- eret_req  in  1  ERET committing in M stage
- epc  in  32  CP0 EPC value
- pc_next  out  32  data input to PC register
- pc_en  out  1  write enable to PC register
- flush  out  1  kill F/D (and D/E) contents this cycle
- bd_f  out  1  instruction currently in F is a delay slot (registered)
- fetch_adel  out  1  pc_cur is an illegal fetch address

## Operation

- State register has two states:
  - RUN: no pending redirect.
  - PEND: a taken branch target is held in pend_tgt[31:0].
- Per-cycle priority, highest first: reset > exc_req > eret_req > stall > pending redirect > br_taken > sequential.
- reset:
  - pc_en=0, pc_next=RESET_PC, flush=0.
  - Next state RUN, pend_tgt←0, bd_f←0.
- exc_req:
  - pc_next=EXC_VECTOR, pc_en=1, flush=1. This ignores stall.
  - Next state RUN. Any pending target is discarded. bd_f←0.
- eret_req (no exc_req):
  - pc_next=epc, pc_en=1, flush=1. This ignores stall.
  - Next state RUN. Pending target is discarded. bd_f←0.
- stall=1 (no exc/eret):
  - pc_en=0, flush=0.
  - In RUN with br_taken=1: pend_tgt←br_target, next state PEND.
  - In PEND: pend_tgt holds. A repeated br_taken is ignored.
  - bd_f holds.
- stall=0 in PEND:
  - pc_next=pend_tgt, pc_en=1, next state RUN. Current br_taken/br_target are ignored.
- stall=0 in RUN:
  - pc_en=1.
  - pc_next=br_target if br_taken, else pc_cur+4. The +4 wraps modulo 2^32.
- bd_f update when stall=0 and no exc/eret: bd_f←is_br.
- fetch_adel=1 iff any of:
  - pc_cur[1:0]≠0
  - pc_cur<IMEM_LO
  - pc_cur>IMEM_HI
  - Comparison is unsigned. fetch_adel is pure combinational and is independent of state.
- flush=1 only on exc_req or eret_req cycles.

## Timing

- pc_next, pc_en and flush are combinational from inputs, state and pend_tgt. The PC register updates on the same edge.
- Redirect latency:
  - Branch resolved in D with stall=0: PC equals the target one edge later. The delay slot is already in F.
  - Branch seen during a stall: PC equals the target on the first edge with stall=0.
- exc_req/eret_req: PC equals the vector/epc one edge later, even mid-stall or in PEND.
- bd_f is valid the cycle after the branch leaves D, aligned with the delay-slot instruction in F.
- Reset asserted mid-PEND: pending target is lost and bd_f=0 at the next edge.

## Test plan

- Sequential fetch: reset, then pc_cur=0x3000 with no requests. Require pc_next=0x3004, pc_en=1, bd_f=0, fetch_adel=0.
- Stalled branch:
  - Stimulus: stall=1, br_taken=1, br_target=0x3100 for 3 cycles, then stall=0 with br_target=0x3200.
  - Require pc_en=0 for 3 cycles, then pc_next=0x3100, pc_en=1.
  - Require state back to RUN and bd_f=1 after the release edge when is_br=1.
- Exception over stall: state PEND (pend_tgt=0x3100), stall=1, exc_req=1. Require pc_next=0x4180, pc_en=1, flush=1, then state RUN and bd_f=0.
- ERET vs exception:
  - exc_req=1, eret_req=1, epc=0x3044: require pc_next=0x4180.
  - eret_req=1 alone: require pc_next=0x3044, flush=1.
- Fetch address check:
  - pc_cur=0x3002, 0x2FFC and 0x7000: require fetch_adel=1 for each.
  - pc_cur=0x6FFC: require fetch_adel=0.
- Reset mid-PEND: in PEND, assert reset. Require pc_en=0 and pc_next=0x3000. After release with stall=0 and br_taken=0, require pc_next=pc_cur+4.
